// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divide controller: RISC-V funct3 divide codes,
// handshake levels, FSM state encoding and the cache lookup key.
package div_ctrl_pkg;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  localparam logic DIV_START    = 1'b1;
  localparam logic RESULT_READY = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_RUN  = 4'b0010,
    ST_DONE = 4'b0100,
    ST_COOL = 4'b1000
  } state_e;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
  } div_key_t;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == INST_DIV) || (op == INST_DIVU) ||
           (op == INST_REM) || (op == INST_REMU);
  endfunction

endpackage

// File: rtl/div_cache.sv
// One-entry result cache: combinational hit/result lookup, synchronous write.
module div_cache
  import div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  div_key_t    lookup_i,
  output logic        hit_o,
  output logic [31:0] result_o,
  input  logic        we_i,
  input  div_key_t    wkey_i,
  input  logic [31:0] wresult_i
);

  logic        valid_q;
  div_key_t    key_q;
  logic [31:0] result_q;

  // NOTE: non-blocking assignments for all flops so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (we_i) begin
      valid_q <= 1'b1;
    end
  end

  // NOTE: payload storage has no reset; valid_q alone decides whether it is meaningful.
  always_ff @(posedge clk) begin
    if (we_i) begin
      key_q    <= wkey_i;
      result_q <= wresult_i;
    end
  end

  assign hit_o    = valid_q && (key_q == lookup_i);
  assign result_o = result_q;

endmodule

// File: rtl/div_ctrl.sv
// Divide controller between EX and a multi-cycle divider: latches operands,
// holds the start request, stalls the pipe and reuses the last result on a repeat.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic [4:0]  rd_i,
  input  logic        flush_i,
  output logic        div_start_o,
  output logic [2:0]  div_op_o,
  output logic [31:0] div_dividend_o,
  output logic [31:0] div_divisor_o,
  input  logic [31:0] div_result_i,
  input  logic        div_busy_i,
  input  logic        div_ready_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_rd_o
);

  state_e      state_q;
  logic        start_q;
  logic        wb_valid_q;
  logic [2:0]  op_q;
  logic [31:0] dividend_q;
  logic [31:0] divisor_q;
  logic [31:0] result_q;
  logic [4:0]  rd_q;

  logic        req_ok;
  logic        cache_hit;
  logic [31:0] cache_result;
  logic        cache_we;
  div_key_t    lookup_key;
  div_key_t    write_key;

  // Completion is signalled solely by div_ready_i; busy is informational.
  logic unused_busy;
  assign unused_busy = div_busy_i;

  assign req_ok     = req_i && !flush_i && is_div_op(op_i);
  assign cache_we   = (state_q == ST_RUN) && !flush_i && (div_ready_i == RESULT_READY);
  assign lookup_key = '{op: op_i, dividend: dividend_i, divisor: divisor_i};
  assign write_key  = '{op: op_q, dividend: dividend_q, divisor: divisor_q};

  div_cache u_cache (
    .clk       (clk),
    .rst_n     (rst_n),
    .lookup_i  (lookup_key),
    .hit_o     (cache_hit),
    .result_o  (cache_result),
    .we_i      (cache_we),
    .wkey_i    (write_key),
    .wresult_i (div_result_i)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      op_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
      rd_q       <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (req_ok) begin
            rd_q <= rd_i;
            if (cache_hit) begin
              result_q   <= cache_result;
              wb_valid_q <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              op_q       <= op_i;
              dividend_q <= dividend_i;
              divisor_q  <= divisor_i;
              start_q    <= DIV_START;
              state_q    <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (flush_i) begin
            start_q <= ~DIV_START;
            state_q <= ST_COOL;
          end else if (div_ready_i == RESULT_READY) begin
            result_q   <= div_result_i;
            start_q    <= ~DIV_START;
            wb_valid_q <= 1'b1;
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_COOL;
        ST_COOL: state_q <= ST_IDLE;
        default: begin
          start_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // A request arriving while cooling down must hold EX until the next IDLE accepts it.
  assign stall_o = (state_q == ST_RUN) ||
                   (((state_q == ST_IDLE) || (state_q == ST_COOL)) && req_ok);

  assign div_start_o    = start_q;
  assign div_op_o       = op_q;
  assign div_dividend_o = dividend_q;
  assign div_divisor_o  = divisor_q;
  assign wb_valid_o     = wb_valid_q && !flush_i;
  assign wb_data_o      = result_q;
  assign wb_rd_o        = rd_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed vector table, hand-written corner
// sequences and randomized requests against an arithmetic reference model.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i;
  logic [2:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        div_start_o;
  logic [2:0]  div_op_o;
  logic [31:0] div_dividend_o;
  logic [31:0] div_divisor_o;
  logic [31:0] div_result_i;
  logic        div_busy_i;
  logic        div_ready_i;
  logic        stall_o;
  logic        wb_valid_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;

  logic model_ready;
  logic extra_ready;
  int   lat;
  int   cnt;
  int   checks = 0;
  int   errors = 0;

  // Reference cache: the last operation that completed on the divider.
  bit          mc_valid = 1'b0;
  logic [2:0]  mc_op;
  logic [31:0] mc_a;
  logic [31:0] mc_b;

  assign div_ready_i = model_ready | extra_ready;

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req_i),
    .op_i           (op_i),
    .dividend_i     (dividend_i),
    .divisor_i      (divisor_i),
    .rd_i           (rd_i),
    .flush_i        (flush_i),
    .div_start_o    (div_start_o),
    .div_op_o       (div_op_o),
    .div_dividend_o (div_dividend_o),
    .div_divisor_o  (div_divisor_o),
    .div_result_i   (div_result_i),
    .div_busy_i     (div_busy_i),
    .div_ready_i    (div_ready_i),
    .stall_o        (stall_o),
    .wb_valid_o     (wb_valid_o),
    .wb_data_o      (wb_data_o),
    .wb_rd_o        (wb_rd_o)
  );

  // RISC-V M-extension divide semantics.
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    bit ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'b100:  if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return a; else return sa / sb;
      3'b101:  if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      3'b110:  if (b == 0) return a; else if (ovf) return 32'd0; else return sa % sb;
      3'b111:  if (b == 0) return a; else return a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Divider model: answers 'lat' cycles after it sees start, aborts when start drops.
  initial begin
    model_ready  = 1'b0;
    div_busy_i   = 1'b0;
    div_result_i = '0;
    cnt          = 0;
    forever begin
      @(posedge clk);
      #2;
      model_ready = 1'b0;
      if (!div_start_o) begin
        cnt        = 0;
        div_busy_i = 1'b0;
      end else if (!div_busy_i && cnt == 0) begin
        div_busy_i = 1'b1;
        cnt        = lat;
      end else if (div_busy_i) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          model_ready  = 1'b1;
          div_result_i = ref_div(div_op_o, div_dividend_o, div_divisor_o);
          div_busy_i   = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic checkb(input string name, input logic got, input logic exp);
    check(name, {31'b0, got}, {31'b0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    checkb({tag, "_start"}, div_start_o, 1'b0);
    check({tag, "_op"}, {29'b0, div_op_o}, 32'd0);
    check({tag, "_dividend"}, div_dividend_o, 32'd0);
    check({tag, "_divisor"}, div_divisor_o, 32'd0);
    checkb({tag, "_stall"}, stall_o, 1'b0);
    checkb({tag, "_wb_valid"}, wb_valid_o, 1'b0);
    check({tag, "_wb_data"}, wb_data_o, 32'd0);
    check({tag, "_wb_rd"}, {27'b0, wb_rd_o}, 32'd0);
  endtask

  // Issue one request and hold it until writeback; returns with the DUT cooling down.
  task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] got, output int lat_cyc,
                        output bit first_start, output bit saw_start);
    bit exp_hit;
    bit stall_ok;
    bit seen;
    logic [31:0] exp;
    exp     = ref_div(op, a, b);
    exp_hit = mc_valid && (mc_op == op) && (mc_a == a) && (mc_b == b);
    req_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; rd_i = rd; flush_i = 1'b0;
    #1;
    checkb("stall_on_req", stall_o, 1'b1);
    saw_start = 1'b0; stall_ok = 1'b1; seen = 1'b0; lat_cyc = 0; got = '0; first_start = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      lat_cyc++;
      if (i == 0) first_start = div_start_o;
      if (div_start_o) saw_start = 1'b1;
      if (wb_valid_o) begin
        seen = 1'b1;
        got  = wb_data_o;
        check("wb_rd", {27'b0, wb_rd_o}, {27'b0, rd});
        checkb("stall_low_on_wb", stall_o, 1'b0);
      end else if (!stall_o) begin
        stall_ok = 1'b0;
      end
    end
    checkb("wb_seen", seen, 1'b1);
    check("wb_data_model", got, exp);
    checkb("stall_held_until_wb", stall_ok, 1'b1);
    checkb("start_iff_cache_miss", saw_start, !exp_hit);
    req_i = 1'b0;
    step();
    checkb("wb_one_cycle", wb_valid_o, 1'b0);
    checkb("cool_start_low", div_start_o, 1'b0);
    if (seen && !exp_hit) begin
      mc_valid = 1'b1; mc_op = op; mc_a = a; mc_b = b;
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    bit          hit;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [31:0] got;
    int          lc;
    bit          fs;
    bit          ss;
    bit          run_ok;
    logic [2:0]  p_op;
    logic [31:0] p_a;
    logic [31:0] p_b;
    bit          have_prev;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;

    tbl[0] = '{3'b100, 32'd100,        32'd7,          5'd5,  32'd14,         1'b0};
    tbl[1] = '{3'b110, 32'd100,        32'd7,          5'd6,  32'd2,          1'b0};
    tbl[2] = '{3'b110, 32'd100,        32'd7,          5'd6,  32'd2,          1'b1};
    tbl[3] = '{3'b101, 32'hFFFF_FFFF,  32'd0,          5'd7,  32'hFFFF_FFFF,  1'b0};
    tbl[4] = '{3'b111, 32'd5,          32'd0,          5'd8,  32'd5,          1'b0};
    tbl[5] = '{3'b111, 32'd5,          32'd0,          5'd9,  32'd5,          1'b1};
    tbl[6] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'h8000_0000,  1'b0};
    tbl[7] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'd0,          1'b0};
    tbl[8] = '{3'b101, 32'd100,        32'd7,          5'd12, 32'd14,         1'b0};

    rst_n = 1'b0; req_i = 1'b0; op_i = '0; dividend_i = '0; divisor_i = '0;
    rd_i = '0; flush_i = 1'b0; extra_ready = 1'b0; lat = 5;
    #1;
    check_zero("reset");
    step(); step();
    rst_n = 1'b1;

    // Directed vectors, issued back to back with requests held continuously.
    for (int i = 0; i < 9; i++) begin
      do_req(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, got, lc, fs, ss);
      check($sformatf("tbl%0d_data", i), got, tbl[i].exp);
      checkb($sformatf("tbl%0d_cache_hit", i), !ss, tbl[i].hit);
    end

    // Repeat of a completed REM from IDLE: writeback one cycle after acceptance.
    step();
    do_req(3'b110, 32'd100, 32'd7, 5'd6, got, lc, fs, ss);
    check("rem_first_data", got, 32'd2);
    step();
    do_req(3'b110, 32'd100, 32'd7, 5'd6, got, lc, fs, ss);
    check("rem_hit_latency", lc, 32'd1);
    checkb("rem_hit_no_start", ss, 1'b0);
    step();

    // Flush during DONE suppresses the writeback strobe.
    req_i = 1'b1; op_i = 3'b110; dividend_i = 32'd100; divisor_i = 32'd7; rd_i = 5'd9;
    step();
    checkb("done_wb_before_flush", wb_valid_o, 1'b1);
    flush_i = 1'b1;
    #1;
    checkb("done_flush_wb", wb_valid_o, 1'b0);
    req_i = 1'b0;
    step();
    flush_i = 1'b0;
    step();

    // Flush in IDLE blocks acceptance.
    req_i = 1'b1; op_i = 3'b100; dividend_i = 32'd7; divisor_i = 32'd2; flush_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkb("idle_flush_no_start", div_start_o, 1'b0);
      checkb("idle_flush_no_wb", wb_valid_o, 1'b0);
    end
    req_i = 1'b0; flush_i = 1'b0;

    // Stray ready while idle is ignored.
    extra_ready = 1'b1;
    step();
    extra_ready = 1'b0;
    checkb("stray_ready_no_wb", wb_valid_o, 1'b0);
    checkb("stray_ready_no_stall", stall_o, 1'b0);
    step();
    checkb("stray_ready_no_wb_later", wb_valid_o, 1'b0);

    // Non-divide op codes are not accepted.
    for (int k = 0; k < 2; k++) begin
      req_i = 1'b1; op_i = (k == 0) ? 3'b000 : 3'b011; dividend_i = 32'd9; divisor_i = 32'd3;
      #1;
      checkb("bad_op_no_stall", stall_o, 1'b0);
      step();
      step();
      checkb("bad_op_no_start", div_start_o, 1'b0);
      checkb("bad_op_no_wb", wb_valid_o, 1'b0);
    end
    req_i = 1'b0;
    step();

    // Flush ten cycles into RUN aborts the divide without touching the cache.
    lat = 34;
    req_i = 1'b1; op_i = 3'b100; dividend_i = 32'hFFFF_FFEC; divisor_i = 32'd3; rd_i = 5'd4;
    step();
    checkb("flush_run_started", div_start_o, 1'b1);
    check("flush_run_op_latched", {29'b0, div_op_o}, 32'd4);
    check("flush_run_dividend_latched", div_dividend_o, 32'hFFFF_FFEC);
    run_ok = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      if (!div_start_o || wb_valid_o || !stall_o) run_ok = 1'b0;
    end
    checkb("run_held", run_ok, 1'b1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0; req_i = 1'b0;
    #1;
    checkb("flush_start_drop", div_start_o, 1'b0);
    checkb("flush_no_wb", wb_valid_o, 1'b0);
    step();
    checkb("flush_no_wb_later", wb_valid_o, 1'b0);
    lat = 5;
    do_req(3'b110, 32'd100, 32'd7, 5'd6, got, lc, fs, ss);
    checkb("flush_cache_kept", ss, 1'b0);
    do_req(3'b100, 32'hFFFF_FFEC, 32'd3, 5'd4, got, lc, fs, ss);
    check("div_neg20_by_3", got, 32'hFFFF_FFFA);

    // Reset during RUN abandons the operation and clears the cache.
    lat = 20;
    step();
    req_i = 1'b1; op_i = 3'b100; dividend_i = 32'd100; divisor_i = 32'd3; rd_i = 5'd2;
    for (int i = 0; i < 4; i++) step();
    checkb("pre_reset_running", div_start_o, 1'b1);
    rst_n = 1'b0; req_i = 1'b0;
    mc_valid = 1'b0;
    #1;
    check_zero("mid_run_reset");
    step();
    step();
    rst_n = 1'b1;
    lat = 5;
    do_req(3'b100, 32'hFFFF_FFEC, 32'd3, 5'd4, got, lc, fs, ss);
    checkb("post_reset_first_cycle_start", fs, 1'b1);
    do_req(3'b100, 32'd9, 32'd3, 5'd3, got, lc, fs, ss);
    check("post_reset_div_9_3", got, 32'd3);

    // Randomized requests against the reference model.
    have_prev = 1'b0; p_op = '0; p_a = '0; p_b = '0;
    for (int n = 0; n < 40; n++) begin
      lat  = $urandom_range(1, 12);
      r_op = 3'($urandom_range(0, 7));
      if (!r_op[2]) begin
        req_i = 1'b1; op_i = r_op; dividend_i = $urandom; divisor_i = $urandom;
        #1;
        checkb("rand_bad_op_no_stall", stall_o, 1'b0);
        step();
        checkb("rand_bad_op_no_start", div_start_o, 1'b0);
        req_i = 1'b0;
      end else begin
        if (have_prev && ($urandom_range(0, 2) == 0)) begin
          r_op = p_op; r_a = p_a; r_b = p_b;
        end else begin
          r_a = $urandom;
          case ($urandom_range(0, 5))
            0:       r_b = 32'd0;
            1:       begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
            2, 3:    r_b = 32'($urandom_range(1, 50));
            default: r_b = $urandom;
          endcase
        end
        do_req(r_op, r_a, r_b, 5'($urandom_range(0, 31)), got, lc, fs, ss);
        p_op = r_op; p_a = r_a; p_b = r_b; have_prev = 1'b1;
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
